// File: rtl/ntt_core_gf64_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ntt_core_gf64_pkg
// Description : Goldilocks-style prime constants p = 2^W - 2^(W/2) + 1 as
//               functions of the modulus width.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_core_gf64_pkg;

  localparam int GF64_MAX_W = 128;

  function automatic int gf64_mid_w(input int w);
    return w / 2;
  endfunction

  // e = 2^(W/2) - 1, the value that 2^W folds to modulo p
  function automatic logic [GF64_MAX_W-1:0] gf64_e(input int w);
    return (GF64_MAX_W'(1) << gf64_mid_w(w)) - GF64_MAX_W'(1);
  endfunction

  function automatic logic [GF64_MAX_W-1:0] gf64_p(input int w);
    return (GF64_MAX_W'(1) << w) - (GF64_MAX_W'(1) << gf64_mid_w(w)) + GF64_MAX_W'(1);
  endfunction

  // Negative-operand correction p - 2e; always non-negative for even W >= 4
  function automatic logic [GF64_MAX_W-1:0] gf64_p_m2e(input int w);
    return gf64_p(w) - (gf64_e(w) << 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/common_lib_delay_side.sv
`default_nettype none
// ============================================================================
// Module      : common_lib_delay_side
// Description : Fixed-depth delay line for an avail strobe plus side data.
// Revision    : 1.0 - initial release
// ============================================================================
module common_lib_delay_side #(
  parameter int         DEPTH    = 2,
  parameter int         SIDE_W   = 0,
  parameter logic [1:0] RST_SIDE = 2'b00
) (
  input  logic                                   clk,
  input  logic                                   s_rst_n,
  input  logic                                   in_avail,
  input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
  output logic                                   out_avail,
  output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);

  localparam int c_sw = (SIDE_W > 0) ? SIDE_W : 1;
  localparam logic [c_sw-1:0] c_side_rst = RST_SIDE[1] ? {c_sw{1'b1}} : {c_sw{1'b0}};

  logic [DEPTH-1:0] r_avail;
  logic [c_sw-1:0]  r_side [DEPTH];

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_avail <= '0;
    end else begin
      r_avail[0] <= in_avail;
      for (int i = 1; i < DEPTH; i++) begin
        r_avail[i] <= r_avail[i-1];
      end
    end
  end

  generate
    if (RST_SIDE != 2'b00) begin : g_side_rst
      always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_side[i] <= c_side_rst;
          end
        end else begin
          r_side[0] <= in_side;
          for (int i = 1; i < DEPTH; i++) begin
            r_side[i] <= r_side[i-1];
          end
        end
      end
    end else begin : g_side_norst
      always_ff @(posedge clk) begin
        r_side[0] <= in_side;
        for (int i = 1; i < DEPTH; i++) begin
          r_side[i] <= r_side[i-1];
        end
      end
    end
  endgenerate

  assign out_avail = r_avail[DEPTH-1];
  assign out_side  = r_side[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ntt_core_gf64_canon_reduction.sv
`default_nettype none
// ============================================================================
// Module      : ntt_core_gf64_canon_reduction
// Description : Reduces a signed (W+2)-bit partially reduced value to the
//               canonical residue in [0, p), p = 2^W - 2^(W/2) + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_core_gf64_canon_reduction
  import ntt_core_gf64_pkg::*;
#(
  parameter int         MOD_NTT_W = 64,
  parameter bit         IN_PIPE   = 1'b1,
  parameter int         SIDE_W    = 0,
  parameter logic [1:0] RST_SIDE  = 2'b00
) (
  input  logic                                   clk,
  input  logic                                   s_rst_n,
  input  logic [MOD_NTT_W+1:0]                   a,
  output logic [MOD_NTT_W-1:0]                   z,
  input  logic                                   in_avail,
  output logic                                   out_avail,
  input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
  output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);

  localparam int W = MOD_NTT_W;
  localparam logic [W:0]   c_p     = (W+1)'(gf64_p(W));
  localparam logic [W:0]   c_e     = (W+1)'(gf64_e(W));
  localparam logic [W:0]   c_p_m2e = (W+1)'(gf64_p_m2e(W));
  localparam logic [W-1:0] c_p_lo  = c_p[W-1:0];

  generate
    if ((MOD_NTT_W % 2) != 0) begin : g_odd_width
      $fatal(1, "ntt_core_gf64_canon_reduction: MOD_NTT_W must be even");
    end
  endgenerate

  logic [W+1:0] w_a;

  generate
    if (IN_PIPE) begin : g_in_pipe
      logic [W+1:0] r_a;
      always_ff @(posedge clk) begin
        r_a <= a;
      end
      assign w_a = r_a;
    end else begin : g_no_in_pipe
      assign w_a = a;
    end
  endgenerate

  // a = -s*2^(W+1) + h*2^W + l; 2^W == e mod p, so every term is folded into
  // a non-negative sum that stays below 2p.
  logic         w_s;
  logic         w_h;
  logic [W-1:0] w_l;
  logic [W:0]   w_y;
  logic [W:0]   r_y;

  assign {w_s, w_h, w_l} = w_a;
  assign w_y = {1'b0, w_l} + (w_h ? c_e : '0) + (w_s ? c_p_m2e : '0);

  always_ff @(posedge clk) begin
    r_y <= w_y;
  end

  logic         w_ge_p;
  logic [W-1:0] w_y_sub;
  logic [W-1:0] r_z;

  assign w_ge_p  = (r_y >= c_p);
  assign w_y_sub = r_y[W-1:0] - c_p_lo;

  always_ff @(posedge clk) begin
    r_z <= w_ge_p ? w_y_sub : r_y[W-1:0];
  end

  assign z = r_z;

  common_lib_delay_side #(
    .DEPTH    (int'(IN_PIPE) + 2),
    .SIDE_W   (SIDE_W),
    .RST_SIDE (RST_SIDE)
  ) u_delay_side (
    .clk       (clk),
    .s_rst_n   (s_rst_n),
    .in_avail  (in_avail),
    .in_side   (in_side),
    .out_avail (out_avail),
    .out_side  (out_side)
  );

endmodule
`default_nettype wire

// File: tb/tb_ntt_core_gf64_canon_reduction.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_core_gf64_canon_reduction
// Description : Randomized reference-model bench for both IN_PIPE settings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_core_gf64_canon_reduction;

  localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

  logic        clk = 1'b0;
  logic        s_rst_n;
  logic [65:0] a;
  logic        in_avail;
  logic [7:0]  in_side;
  logic [63:0] z1, z0;
  logic        oa1, oa0;
  logic [7:0]  os1, os0;

  always #5 clk = ~clk;

  ntt_core_gf64_canon_reduction #(
    .MOD_NTT_W (64), .IN_PIPE (1'b1), .SIDE_W (8), .RST_SIDE (2'b10)
  ) u_dut_p1 (
    .clk (clk), .s_rst_n (s_rst_n), .a (a), .z (z1),
    .in_avail (in_avail), .out_avail (oa1), .in_side (in_side), .out_side (os1)
  );

  ntt_core_gf64_canon_reduction #(
    .MOD_NTT_W (64), .IN_PIPE (1'b0), .SIDE_W (8), .RST_SIDE (2'b10)
  ) u_dut_p0 (
    .clk (clk), .s_rst_n (s_rst_n), .a (a), .z (z0),
    .in_avail (in_avail), .out_avail (oa0), .in_side (in_side), .out_side (os0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Inputs captured at each rising edge, keyed by edge index
  bit          hv [int];
  logic [63:0] hz [int];
  logic [7:0]  hs [int];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [63:0] ref_mod(input logic [65:0] av);
    logic signed [127:0] x;
    logic signed [127:0] r;
    x = {{62{av[65]}}, av};
    r = x % $signed({64'd0, P});
    if (r < 0) r = r + $signed({64'd0, P});
    return r[63:0];
  endfunction

  function automatic logic [65:0] rand_a();
    logic [95:0] t;
    logic [65:0] base;
    t = {$urandom(), $urandom(), $urandom()};
    case ($urandom_range(7, 0))
      0: begin
        base = 66'($urandom_range(3, 0)) * {2'b00, P};
        return base + 66'(t[3:0]) - 66'(t[7:4]);
      end
      1: return {2'b10, 64'd0} + 66'(t[7:0]);
      2: return {2'b01, {64{1'b1}}} - 66'(t[7:0]);
      default: return t[65:0];
    endcase
  endfunction

  task automatic check_dut(input string nm, input int lat, input logic oa,
                           input logic [63:0] oz, input logic [7:0] os);
    int k;
    bit ev;
    k  = cyc - lat + 1;
    ev = hv.exists(k) ? hv[k] : 1'b0;
    if (!s_rst_n) begin
      check({nm, "_rst_avail"}, 128'(oa), 128'd0);
      check({nm, "_rst_side"},  128'(os), 128'hFF);
    end else begin
      check({nm, "_avail"}, 128'(oa), 128'(ev));
      if (ev) begin
        check({nm, "_z"},     128'(oz), 128'(hz[k]));
        check({nm, "_z_lt_p"}, 128'(oz < P), 128'd1);
        check({nm, "_side"},  128'(os), 128'(hs[k]));
      end
    end
  endtask

  task automatic step(input bit v, input logic [65:0] av, input logic [7:0] sv,
                      input bit rst_assert, input bit has_const, input logic [63:0] cz);
    @(negedge clk);
    check_dut("pipe1", 3, oa1, z1, os1);
    check_dut("pipe0", 2, oa0, z0, os0);
    s_rst_n = !rst_assert;
    if (rst_assert) foreach (hv[i]) hv[i] = 1'b0;
    in_avail = v;
    a        = av;
    in_side  = sv;
    hv[cyc+1] = v && !rst_assert;
    hz[cyc+1] = has_const ? cz : ref_mod(av);
    hs[cyc+1] = sv;
    @(posedge clk);
    cyc++;
  endtask

  logic [65:0] dir_a [6];
  logic [63:0] dir_z [6];

  initial begin
    dir_a[0] = {66{1'b1}};                   dir_z[0] = 64'hFFFF_FFFF_0000_0000;
    dir_a[1] = {2'b00, P};                   dir_z[1] = 64'h0;
    dir_a[2] = {2'b00, P} - 66'd1;           dir_z[2] = 64'hFFFF_FFFF_0000_0000;
    dir_a[3] = 66'h1_FFFF_FFFE_0000_0002;    dir_z[3] = 64'h0;
    dir_a[4] = {2'b01, {64{1'b1}}};          dir_z[4] = 64'h0000_0001_FFFF_FFFD;
    dir_a[5] = {2'b10, 64'd0};               dir_z[5] = 64'hFFFF_FFFD_0000_0003;

    s_rst_n  = 1'b1;
    in_avail = 1'b0;
    a        = '0;
    in_side  = '0;
    #1 s_rst_n = 1'b0;

    repeat (3) step(1'b1, rand_a(), 8'($urandom()), 1'b1, 1'b0, 64'd0);

    for (int i = 0; i < 6; i++) step(1'b1, dir_a[i], 8'(i + 1), 1'b0, 1'b1, dir_z[i]);
    repeat (4) step(1'b0, rand_a(), 8'($urandom()), 1'b0, 1'b0, 64'd0);

    // Back-to-back stream exercises the no-bubble path
    for (int i = 0; i < 10000; i++) step(1'b1, rand_a(), 8'(i), 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(1, 0)), rand_a(), 8'($urandom()), 1'b0, 1'b0, 64'd0);

    // Reset with results in flight; nothing stale may emerge after release
    repeat (3) step(1'b1, rand_a(), 8'($urandom()), 1'b0, 1'b0, 64'd0);
    repeat (3) step(1'b1, rand_a(), 8'($urandom()), 1'b1, 1'b0, 64'd0);
    repeat (5) step(1'b0, rand_a(), 8'($urandom()), 1'b0, 1'b0, 64'd0);
    repeat (4) step(1'b1, rand_a(), 8'($urandom()), 1'b0, 1'b0, 64'd0);
    repeat (5) step(1'b0, rand_a(), 8'($urandom()), 1'b0, 1'b0, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_core_gf64_canon_reduction.md
NTT_CORE_GF64_CANON_REDUCTION -- requirements
Module: ntt_core_gf64_canon_reduction

Interface
REQ-001 SHALL have parameter MOD_NTT_W, default 64, meaning modulus width; must be even; prime p = 2**MOD_NTT_W - 2**(MOD_NTT_W/2) + 1.
REQ-002 SHALL have parameter IN_PIPE, default 1'b1, meaning 1 = register the input before computing, 0 = no input register.
REQ-003 SHALL have parameter SIDE_W, default 0, meaning side-data width; 0 = side data unused.
REQ-004 SHALL have parameter RST_SIDE, default 2'b00, meaning side reset value: [0]=1 resets side to 0, [1]=1 resets side to 1, 00 = side not reset.
REQ-005 SHALL have port clk  input  1  clock; single clock domain, rising edge.
REQ-006 SHALL have port s_rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port a  input  MOD_NTT_W+2  2s-complement partially reduced operand, range [-2**(MOD_NTT_W+1), 2**(MOD_NTT_W+1)).
REQ-008 SHALL have port z  output  MOD_NTT_W  canonical residue in [0, p).
REQ-009 SHALL have port in_avail  input  1  qualifies a and in_side.
REQ-010 SHALL have port out_avail  output  1  qualifies z and out_side.
REQ-011 SHALL have port in_side  input  SIDE_W  side data travelling with a.
REQ-012 SHALL have port out_side  output  SIDE_W  side data aligned with z.

Function
REQ-013 SHALL raise $fatal at elaboration if MOD_NTT_W is odd.
REQ-014 SHALL have a fixed latency of IN_PIPE+2 cycles from in_avail to out_avail, with no backpressure and one result accepted per cycle.
REQ-015 Stage s0 (optional, IN_PIPE) SHALL register a. Data registers SHALL load every cycle without an enable and SHALL not be reset.
REQ-016 Stage s1 SHALL split a as -s*2**(W+1) + h*2**W + l (s = sign bit, h = bit W, l = bits [W-1:0], W = MOD_NTT_W, e = 2**(W/2)-1).
REQ-017 Stage s1 SHALL compute y = l + h*e - 2*s*e + s*p as an unsigned (W+1)-bit value; y SHALL lie in [0, 2p) for every legal a.
REQ-018 Stage s2 SHALL output z = (y >= p) ? y - p : y, registered.
REQ-019 avail and side SHALL be delayed by the same number of cycles as the data, for example using the common_lib_delay_side primitive.
REQ-020 out_side SHALL be the in_side sampled with the same in_avail.
REQ-021 When in_avail=0, z SHALL be don't-care and out_avail SHALL be 0 in the matching cycle.
REQ-022 Back-to-back in_avail SHALL produce back-to-back out_avail with no bubbles.

Reset
REQ-023 While s_rst_n=0, every avail register SHALL be 0, so out_avail=0.
REQ-024 While s_rst_n=0, side registers SHALL follow RST_SIDE; z is not reset (don't-care).
REQ-025 Results in flight when reset is asserted mid-stream SHALL be discarded: out_avail SHALL stay 0 until IN_PIPE+2 cycles after the first in_avail following deassertion.

Structure
REQ-026 The GF64 constants p, e and MID_W SHALL be functions of MOD_NTT_W placed in the shared ntt_core_gf64 package, not local literals.
REQ-027 The avail/side pipeline SHALL reuse the common_lib_delay_side sub-module; the arithmetic SHALL stay flat in this module.

Verification (MOD_NTT_W=64, p=0xFFFFFFFF00000001)
REQ-028 a=-1 (all ones) -> z=0xFFFFFFFF00000000 after IN_PIPE+2 cycles.
REQ-029 a=p -> z=0; a=p-1 -> z=0xFFFFFFFF00000000; a=2p -> z=0.
REQ-030 a=2**65-1 -> z=0x00000001FFFFFFFD; a=-2**65 -> z=0xFFFFFFFD00000003.
REQ-031 Random back-to-back stream of 10k legal a with SIDE_W=8 -> every z equals a mod p, z < p, out_side order preserved, no bubbles; run with IN_PIPE=0 and IN_PIPE=1.
REQ-032 Assert s_rst_n=0 while 3 results are in flight, RST_SIDE=2'b10 -> out_avail=0 and out_side=0xFF during reset, with no stale result after release.
